// File: rtl/dsp_pkg.sv
// Shared DSP definitions: the opcode set, the packed instruction word and the NOP constant.
// The packing puts the opcode in the MSBs, and OpNop is zero, so NOP is the all-zeros word.
package dsp_pkg;

  localparam int unsigned SAMPLE_ADDR_WIDTH = 12;
  localparam int unsigned PARAM_ADDR_WIDTH  = 12;

  typedef enum logic [7:0] {
    OpNop   = 8'h00,
    OpLoad  = 8'h01,
    OpMac   = 8'h02,
    OpAdd   = 8'h03,
    OpMul   = 8'h04,
    OpStore = 8'h05,
    OpOut   = 8'h06
  } opcode_t;

  typedef struct packed {
    opcode_t                      opcode;
    logic [SAMPLE_ADDR_WIDTH-1:0] sample_addr;
    logic [PARAM_ADDR_WIDTH-1:0]  param_addr;
  } instr_t;

  localparam instr_t NOP_INSTR = instr_t'('0);

endpackage

// File: rtl/dsp_sequencer.sv
// Frame-synchronous instruction sequencer feeding the DSP core's instr_in.
// On each accepted frame_sync it streams program words 0..last from a synchronous RAM,
// then issues DRAIN_CYCLES NOPs so the core pipeline drains, and pulses frame_done.
// Optional feature macro: DSP_SEQUENCER_FRAME_COUNT_EN (live frame counter; tied to 0 otherwise).
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned INSTR_ADDR_WIDTH  = 10,
  parameter int unsigned DRAIN_CYCLES      = 4,
  parameter int unsigned FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_sync,
  input  logic [INSTR_ADDR_WIDTH-1:0]  prog_last,
  input  logic                         overrun_clear,
  output logic [INSTR_ADDR_WIDTH-1:0]  imem_rd_addr,
  input  instr_t                       imem_rd_data,
  output instr_t                       instr_out,
  output logic                         running,
  output logic                         frame_done,
  output logic                         overrun,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

  localparam int unsigned DrainCntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StRun,
    StDrain
  } state_e;

  state_e                      state_q, state_d;
  logic [INSTR_ADDR_WIDTH-1:0] last_q, last_d;
  logic [INSTR_ADDR_WIDTH-1:0] addr_q, addr_d;
  instr_t                      instr_q, instr_d;
  // Set when the RAM word arriving next cycle is the one at last_q.
  logic                        word_last_q, word_last_d;
  logic [DrainCntW-1:0]        drain_q, drain_d;
  logic                        done_q, done_d;
  logic                        overrun_q, overrun_d;

  // Next-state logic for the FSM, address walker and drain counter
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    instr_d     = NOP_INSTR;
    word_last_d = 1'b0;
    drain_d     = drain_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (frame_sync) begin
          last_d  = prog_last;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Address 0 is being read this cycle; step on unless the program is one word long.
        word_last_d = (addr_q == last_q);
        if (addr_q != last_q) begin
          addr_d = addr_q + INSTR_ADDR_WIDTH'(1);
        end
        state_d = StRun;
      end
      StRun: begin
        instr_d = imem_rd_data;
        if (word_last_q) begin
          state_d = StDrain;
          drain_d = DrainCntW'(DRAIN_CYCLES - 1);
        end else begin
          word_last_d = (addr_q == last_q);
          if (addr_q != last_q) begin
            addr_d = addr_q + INSTR_ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = StIdle;
        end else begin
          drain_d = drain_q - DrainCntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sticky overrun: a rejected frame_sync beats a simultaneous clear
  always_comb begin
    overrun_d = overrun_q;
    if (frame_sync && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end else if (overrun_clear) begin
      overrun_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      last_q      <= '0;
      addr_q      <= '0;
      instr_q     <= NOP_INSTR;
      word_last_q <= 1'b0;
      drain_q     <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      word_last_q <= word_last_d;
      drain_q     <= drain_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef DSP_SEQUENCER_FRAME_COUNT_EN
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

  // Completed-frame counter, wraps naturally
  always_comb begin
    frame_count_d = frame_count_q;
    if (done_d) begin
      frame_count_d = frame_count_q + FRAME_COUNT_WIDTH'(1);
    end
  end

  // Frame counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

  assign imem_rd_addr = addr_q;
  assign instr_out    = instr_q;
  assign running      = (state_q != StIdle);
  assign frame_done   = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Self-checking bench for dsp_sequencer: a synchronous RAM model feeds the DUT, every accepted
// frame pushes its expected instr_out/frame_done stream into a queue, and a negedge monitor pops
// and compares. Honours DSP_SEQUENCER_FRAME_COUNT_EN for the frame_count expectations.
module tb_dsp_sequencer;
  import dsp_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DC = 4;
  localparam int unsigned FW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_sync = 1'b0;
  logic [AW-1:0] prog_last = '0;
  logic          overrun_clear = 1'b0;
  logic [AW-1:0] imem_rd_addr;
  instr_t        imem_rd_data;
  instr_t        instr_out;
  logic          running;
  logic          frame_done;
  logic          overrun;
  logic [FW-1:0] frame_count;

  always #5 clk = ~clk;

  dsp_sequencer #(
    .INSTR_ADDR_WIDTH (AW),
    .DRAIN_CYCLES     (DC),
    .FRAME_COUNT_WIDTH(FW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_sync   (frame_sync),
    .prog_last    (prog_last),
    .overrun_clear(overrun_clear),
    .imem_rd_addr (imem_rd_addr),
    .imem_rd_data (imem_rd_data),
    .instr_out    (instr_out),
    .running      (running),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .frame_count  (frame_count)
  );

  // Synchronous instruction RAM: data one cycle after the address
  instr_t mem [2**AW];
  always @(posedge clk) imem_rd_data <= mem[imem_rd_addr];

  // cyc equals the index of the most recent posedge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cyc;
    instr_t instr;
    logic   done;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [FW-1:0] cnt_model = '0;
  logic [AW-1:0] cur_last = '0;
  logic          mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] exp_count();
`ifdef DSP_SEQUENCER_FRAME_COUNT_EN
    return cnt_model;
`else
    return '0;
`endif
  endfunction

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check_eq("instr_out", 32'(instr_out), 32'(e.instr));
        check_eq("frame_done", 32'(frame_done), 32'(e.done));
        if (e.done) begin
          cnt_model = cnt_model + FW'(1);
          check_eq("frame_count", 32'(frame_count), 32'(exp_count()));
        end
      end else begin
        check_eq("idle_instr", 32'(instr_out), 32'(NOP_INSTR));
        check_eq("idle_done", 32'(frame_done), 32'(1'b0));
      end
      if (running) check_eq("addr_bound", 32'(imem_rd_addr <= cur_last), 32'(1'b1));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Call at a negedge: frame_sync is sampled at the next edge, k.
  task automatic start_frame(input int l, output int k);
    prog_last  = AW'(l);
    frame_sync = 1'b1;
    k          = cyc + 1;
    cur_last   = AW'(l);
    for (int n = 0; n <= l; n++) exp_q.push_back('{k + 2 + n, mem[n], 1'b0});
    for (int d = 1; d <= int'(DC); d++) exp_q.push_back('{k + 2 + l + d, NOP_INSTR, d == int'(DC)});
    tick();
    frame_sync = 1'b0;
    prog_last  = AW'($urandom);  // must not affect the running frame
  endtask

  task automatic pulse_sync(input logic clr);
    frame_sync    = 1'b1;
    overrun_clear = clr;
    tick();
    frame_sync    = 1'b0;
    overrun_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int k2;
    for (int i = 0; i < 2**AW; i++) mem[i] = instr_t'($urandom);

    // Reset values
    repeat (3) tick();
    check_eq("rst_instr", 32'(instr_out), 32'(NOP_INSTR));
    check_eq("rst_addr", 32'(imem_rd_addr), 32'(0));
    check_eq("rst_running", 32'(running), 32'(0));
    check_eq("rst_done", 32'(frame_done), 32'(0));
    check_eq("rst_overrun", 32'(overrun), 32'(0));
    check_eq("rst_count", 32'(frame_count), 32'(0));
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Basic frame: L=3 with frame_sync at edge 10
    wait_until(9);
    start_frame(3, k);
    tick();
    check_eq("running", 32'(running), 32'(1));
    wait_until(k + 3 + 3 + int'(DC));
    check_eq("overrun_basic", 32'(overrun), 32'(0));

    // Single-word program
    start_frame(0, k);
    wait_until(k + 8);

    // Overrun during RUN; frame still completes on schedule
    start_frame(5, k);
    wait_until(k + 3);
    pulse_sync(1'b0);
    check_eq("overrun_set", 32'(overrun), 32'(1));
    tick();
    check_eq("overrun_sticky", 32'(overrun), 32'(1));
    wait_until(k + 3 + 5 + int'(DC));
    check_eq("overrun_after", 32'(overrun), 32'(1));

    // Clear together with a rejected sync: set wins; clear alone clears
    start_frame(4, k);
    wait_until(k + 3);
    pulse_sync(1'b1);
    check_eq("overrun_set_wins", 32'(overrun), 32'(1));
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    check_eq("overrun_cleared", 32'(overrun), 32'(0));
    wait_until(k + 3 + 4 + int'(DC));

    // Back-to-back: earliest legal sync accepted, one cycle earlier rejected
    start_frame(2, k);
    wait_until(k + 2 + 2 + int'(DC));
    start_frame(2, k2);
    check_eq("b2b_no_overrun", 32'(overrun), 32'(0));
    check_eq("b2b_started", 32'(k2), 32'(k + 3 + 2 + int'(DC)));
    wait_until(k2 + 1 + 2 + int'(DC));
    pulse_sync(1'b0);
    check_eq("b2b_early_overrun", 32'(overrun), 32'(1));
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    wait_until(cyc + 3);

    // Reset mid-frame while word 2 is due
    start_frame(5, k);
    wait_until(k + 3);
    reset_n = 1'b0;
    while (exp_q.size() != 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    cnt_model = '0;
    tick();
    reset_n = 1'b1;
    check_eq("abort_instr", 32'(instr_out), 32'(NOP_INSTR));
    check_eq("abort_addr", 32'(imem_rd_addr), 32'(0));
    check_eq("abort_running", 32'(running), 32'(0));
    check_eq("abort_count", 32'(frame_count), 32'(0));
    wait_until(cyc + 8);
    start_frame(3, k);
    wait_until(k + 3 + 3 + int'(DC));

`ifdef DSP_SEQUENCER_FRAME_COUNT_EN
    // Counter wrap from all-ones
    start_frame(1, k);
    tick();
    force dut.frame_count_q = 16'hFFFF;
    cnt_model = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    wait_until(k + 3 + 1 + int'(DC));
    check_eq("count_wrapped", 32'(frame_count), 32'(0));
`else
    check_eq("count_tied_zero", 32'(frame_count), 32'(0));
`endif

    wait_until(cyc + 10);
    check_eq("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
